// File: rtl/alu_branch_resolve_stage.sv
// alu_branch_resolve_stage
// Registered stage after the ALU. It captures the ALU result, keeps the
// architectural flag register {Z,S,C,V}, resolves conditional and
// unconditional branches, and presents next-PC, redirect and link-register
// write data to writeback through a one-entry output register.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holds valid and its payload stable
// until the transfer. in_ready depends only on the output register state and
// out_ready (never on in_valid). The output payload is stable for as long as
// out_valid && !out_ready.

module alu_branch_resolve_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    // upstream side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ALUres,
    input  logic             zeroFlag,
    input  logic             signFlag,
    input  logic             carryFlag,
    input  logic             overflow,
    input  logic             flag_we,
    input  logic [3:0]       br_op,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] br_target,

    // downstream side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_q,
    output logic [WIDTH-1:0] next_pc,
    output logic             redirect,
    output logic             link_we,
    output logic [WIDTH-1:0] link_data,
    output logic             illegal_br,
    output logic [3:0]       flags_q
);

    // Branch opcodes. Anything above BR_BNCY is illegal.
    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_B    = 4'd1;
    localparam logic [3:0] BR_BR   = 4'd2;
    localparam logic [3:0] BR_BL   = 4'd3;
    localparam logic [3:0] BR_BLTZ = 4'd4;
    localparam logic [3:0] BR_BZ   = 4'd5;
    localparam logic [3:0] BR_BNZ  = 4'd6;
    localparam logic [3:0] BR_BCY  = 4'd7;
    localparam logic [3:0] BR_BNCY = 4'd8;

    // Bit positions inside flags_q.
    localparam int FLAG_Z = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    logic             accept;
    logic             taken;
    logic             is_link;
    logic             is_illegal;
    logic [WIDTH-1:0] next_pc_d;
    logic [WIDTH-1:0] link_data_d;
    logic [3:0]       flags_d;
    logic             stored_carry;

    // The output slot is free when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // bcy/bncy look at the carry as it stood before this instruction, so a
    // flag-writing bcy/bncy still branches on the previous C.
    assign stored_carry = flags_q[FLAG_C];

    // Decode br_op into taken / link / illegal.
    always_comb begin
        taken      = 1'b0;
        is_link    = 1'b0;
        is_illegal = 1'b0;
        case (br_op)
            BR_NONE: taken = 1'b0;
            BR_B:    taken = 1'b1;
            BR_BR:   taken = 1'b1;
            BR_BL: begin
                taken   = 1'b1;
                is_link = 1'b1;
            end
            // The ALU passes rs through for these, so its live flags
            // describe the operand being tested.
            BR_BLTZ: taken = signFlag;
            BR_BZ:   taken = zeroFlag;
            BR_BNZ:  taken = !zeroFlag;
            BR_BCY:  taken = stored_carry;
            BR_BNCY: taken = !stored_carry;
            default: begin
                taken      = 1'b0;
                is_illegal = 1'b1;
            end
        endcase
    end

    // Select next PC, link data and the candidate flag value.
    always_comb begin
        next_pc_d   = taken ? br_target : pc_plus4;
        link_data_d = is_link ? pc_plus4 : '0;
        flags_d     = flags_q;
        if (flag_we) begin
            flags_d[FLAG_Z] = zeroFlag;
            flags_d[FLAG_S] = signFlag;
            flags_d[FLAG_C] = carryFlag;
            flags_d[FLAG_V] = overflow;
        end
    end

    // One-entry output register: load on accept, empty on drain, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            res_q      <= '0;
            next_pc    <= '0;
            redirect   <= 1'b0;
            link_we    <= 1'b0;
            link_data  <= '0;
            illegal_br <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            res_q      <= ALUres;
            next_pc    <= next_pc_d;
            redirect   <= taken;
            link_we    <= is_link;
            link_data  <= link_data_d;
            illegal_br <= is_illegal;
        end else if (out_ready) begin
            // Data registers keep their last values once drained.
            out_valid  <= 1'b0;
        end
    end

    // Architectural flags change only on an accepted flag-writing instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (accept) begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_branch_resolve_stage.sv
// Bench for alu_branch_resolve_stage: directed scenarios plus randomized
// instructions under random backpressure, checked through an expected queue.

module tb_alu_branch_resolve_stage;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   alu_res;
    logic           zero_flag;
    logic           sign_flag;
    logic           carry_flag;
    logic           ovf_flag;
    logic           flag_we;
    logic [3:0]     br_op;
    logic [W-1:0]   pc_plus4;
    logic [W-1:0]   br_target;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   res_q;
    logic [W-1:0]   next_pc;
    logic           redirect;
    logic           link_we;
    logic [W-1:0]   link_data;
    logic           illegal_br;
    logic [3:0]     flags_q;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] npc;
        logic         rd;
        logic         lwe;
        logic [W-1:0] ld;
        logic         ill;
        logic [3:0]   fl;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [3:0]       model_flags;
    int               bp_mode;
    bit               mon_en;
    int               last_wait;

    alu_branch_resolve_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUres     (alu_res),
        .zeroFlag   (zero_flag),
        .signFlag   (sign_flag),
        .carryFlag  (carry_flag),
        .overflow   (ovf_flag),
        .flag_we    (flag_we),
        .br_op      (br_op),
        .pc_plus4   (pc_plus4),
        .br_target  (br_target),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res_q      (res_q),
        .next_pc    (next_pc),
        .redirect   (redirect),
        .link_we    (link_we),
        .link_data  (link_data),
        .illegal_br (illegal_br),
        .flags_q    (flags_q)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model: branch rules applied to the instruction on the inputs,
    // flags updated after the branch decision.
    function automatic void model_push();
        exp_t e;
        logic tk;
        case (br_op)
            4'd1, 4'd2, 4'd3: tk = 1'b1;
            4'd4:             tk = sign_flag;
            4'd5:             tk = zero_flag;
            4'd6:             tk = !zero_flag;
            4'd7:             tk = model_flags[1];
            4'd8:             tk = !model_flags[1];
            default:          tk = 1'b0;
        endcase
        e.res = alu_res;
        e.npc = tk ? br_target : pc_plus4;
        e.rd  = tk;
        e.lwe = (br_op == 4'd3);
        e.ld  = (br_op == 4'd3) ? pc_plus4 : '0;
        e.ill = (br_op > 4'd8);
        if (flag_we) model_flags = {zero_flag, sign_flag, carry_flag, ovf_flag};
        e.fl  = model_flags;
        exp_q.push_back(e);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step_ready();
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 99) >= 30);
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            step_ready();
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] res, input logic [3:0] fl, input logic fwe,
                        input logic [3:0] op, input logic [W-1:0] pc4, input logic [W-1:0] tgt);
        bit done;
        done      = 1'b0;
        last_wait = 0;
        alu_res   = res;
        {zero_flag, sign_flag, carry_flag, ovf_flag} = fl;
        flag_we   = fwe;
        br_op     = op;
        pc_plus4  = pc4;
        br_target = tgt;
        in_valid  = 1'b1;
        step_ready();
        while (!done) begin
            #2;
            if (in_ready) begin
                model_push();
                done = 1'b1;
            end
            @(negedge clk);
            if (!done) begin
                last_wait++;
                step_ready();
                if (last_wait > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout actual=%0d required<=50", last_wait);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        exp_t snap;
        exp_t e;
        bit   prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en || rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check_val("stall_res", res_q, snap.res);
                check_val("stall_next_pc", next_pc, snap.npc);
                check_val("stall_redirect", W'(redirect), W'(snap.rd));
                check_val("stall_link_data", link_data, snap.ld);
                check_val("stall_flags", W'(flags_q), W'(snap.fl));
                check_val("stall_out_valid", W'(out_valid), W'(1));
            end
            if (out_valid && !out_ready) check_val("stall_in_ready", W'(in_ready), W'(0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=res 0x%0h required=no output", res_q);
                end else begin
                    e = exp_q.pop_front();
                    check_val("res_q", res_q, e.res);
                    check_val("next_pc", next_pc, e.npc);
                    check_val("redirect", W'(redirect), W'(e.rd));
                    check_val("link_we", W'(link_we), W'(e.lwe));
                    check_val("link_data", link_data, e.ld);
                    check_val("illegal_br", W'(illegal_br), W'(e.ill));
                    check_val("flags_q", W'(flags_q), W'(e.fl));
                end
            end
            snap.res   = res_q;
            snap.npc   = next_pc;
            snap.rd    = redirect;
            snap.lwe   = link_we;
            snap.ld    = link_data;
            snap.ill   = illegal_br;
            snap.fl    = flags_q;
            prev_stall = out_valid && !out_ready;
        end
    end

    // ---------------- reset + stimulus ----------------
    initial begin : stimulus
        rst         = 1'b1;
        in_valid    = 1'b0;
        alu_res     = '0;
        {zero_flag, sign_flag, carry_flag, ovf_flag} = 4'b0000;
        flag_we     = 1'b0;
        br_op       = 4'd0;
        pc_plus4    = '0;
        br_target   = '0;
        out_ready   = 1'b0;
        model_flags = 4'b0000;
        bp_mode     = 0;
        mon_en      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_out_valid", W'(out_valid), W'(0));
        check_val("rst_res_q", res_q, '0);
        check_val("rst_next_pc", next_pc, '0);
        check_val("rst_flags", W'(flags_q), W'(0));
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        #1;
        check_val("rst_in_ready", W'(in_ready), W'(1));
        @(negedge clk);

        // add (C=1, flags written) then bcy using stored C
        send(32'd360, 4'b0010, 1'b1, 4'd0, 32'h10, 32'h999);
        send(32'd7,   4'b0000, 1'b0, 4'd7, 32'h40, 32'h100);
        // bz / bnz on live Z, bltz on live S
        send(32'd0,          4'b1000, 1'b0, 4'd5, 32'h50, 32'h200);
        send(32'd0,          4'b1000, 1'b0, 4'd6, 32'h50, 32'h200);
        send(32'hFFFFFF0D,   4'b0100, 1'b0, 4'd4, 32'h60, 32'h300);
        // bl
        send(32'd1, 4'b0000, 1'b0, 4'd3, 32'h24, 32'h80);
        // stored C=1, then flag_we clearing C alongside bncy: old C -> not taken
        send(32'd2, 4'b0010, 1'b1, 4'd0, 32'h70, 32'h400);
        send(32'd3, 4'b0000, 1'b1, 4'd8, 32'h74, 32'h500);
        send(32'd4, 4'b0000, 1'b0, 4'd8, 32'h78, 32'h600);
        // illegal opcode
        send(32'd5, 4'b0000, 1'b0, 4'd12, 32'h90, 32'h700);
        idle(3);

        // backpressure: one entry parked, next instruction held for 3 cycles
        bp_mode = 2;
        send(32'hA, 4'b0101, 1'b1, 4'd1, 32'h100, 32'h180);
        out_ready  = 1'b0;
        alu_res    = 32'hB;
        {zero_flag, sign_flag, carry_flag, ovf_flag} = 4'b1010;
        flag_we    = 1'b1;
        br_op      = 4'd0;
        in_valid   = 1'b1;
        repeat (3) begin
            #2;
            check_val("bp_in_ready", W'(in_ready), W'(0));
            check_val("bp_flags_frozen", W'(flags_q), W'(4'b0101));
            @(negedge clk);
        end
        bp_mode = 0;
        send(32'hB, 4'b1010, 1'b1, 4'd0, 32'h104, 32'h180);
        check_val("bp_release_wait", W'(last_wait), W'(0));
        send(32'hC, 4'b0000, 1'b0, 4'd2, 32'h108, 32'h1C0);
        check_val("bp_b2b_wait_c", W'(last_wait), W'(0));
        send(32'hD, 4'b0001, 1'b1, 4'd0, 32'h10C, 32'h1C0);
        check_val("bp_b2b_wait_d", W'(last_wait), W'(0));
        idle(3);

        // randomized instructions under random backpressure
        bp_mode = 1;
        repeat (300) begin
            send($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        bp_mode = 0;
        idle(4);
        check_val("queue_drained", W'(exp_q.size()), W'(0));

        // reset in the middle of a stall with all flags set and in_valid high
        bp_mode = 2;
        send(32'hEE, 4'b1111, 1'b1, 4'd1, 32'h200, 32'h300);
        idle(2);
        #1;
        check_val("pre_rst_out_valid", W'(out_valid), W'(1));
        check_val("pre_rst_flags", W'(flags_q), W'(4'b1111));
        @(negedge clk);
        mon_en    = 1'b0;
        alu_res   = 32'h55;
        {zero_flag, sign_flag, carry_flag, ovf_flag} = 4'b1111;
        flag_we   = 1'b1;
        br_op     = 4'd3;
        pc_plus4  = 32'h44;
        br_target = 32'h88;
        in_valid  = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        rst       = 1'b0;
        #1;
        check_val("mid_rst_out_valid", W'(out_valid), W'(0));
        check_val("mid_rst_res_q", res_q, '0);
        check_val("mid_rst_next_pc", next_pc, '0);
        check_val("mid_rst_redirect", W'(redirect), W'(0));
        check_val("mid_rst_link_we", W'(link_we), W'(0));
        check_val("mid_rst_link_data", link_data, '0);
        check_val("mid_rst_illegal", W'(illegal_br), W'(0));
        check_val("mid_rst_flags", W'(flags_q), W'(0));
        check_val("mid_rst_in_ready", W'(in_ready), W'(1));
        exp_q.delete();
        model_flags = 4'b0000;
        mon_en      = 1'b1;
        bp_mode     = 0;
        @(negedge clk);
        // after reset, bcy must see the cleared carry
        send(32'h77, 4'b0000, 1'b0, 4'd7, 32'h300, 32'h400);
        idle(3);
        check_val("final_queue_drained", W'(exp_q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
